// File: rtl/mem_wb_pipe_pkg.sv
// Shared types for the MEM->WB pipeline stage: default core widths,
// the writeback bundle layout and the stage occupancy states.
package mem_wb_pipe_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int REG_AW_DEF = 5;
  localparam int RS_W_DEF   = 2;
  localparam int CNT_W_DEF  = 32;

  // Writeback bundle at the core's default widths; field order is shared by
  // the width-parametrised copy inside mem_wb_pipe.
  typedef struct packed {
    logic                  reg_write;
    logic [RS_W_DEF-1:0]   result_src;
    logic [WIDTH_DEF-1:0]  alu_result;
    logic [REG_AW_DEF-1:0] rd;
    logic [WIDTH_DEF-1:0]  imm_ext;
    logic [WIDTH_DEF-1:0]  pc_plus4;
    logic [WIDTH_DEF-1:0]  read_data;
  } wb_bundle_t;

  // Occupancy of the two-entry buffer: nothing, main only, main and skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/skid_buf2.sv
// Generic two-entry valid/ready skid buffer over a packed payload.
// Handshake: a transfer happens on a rising edge where valid && ready on that
// side; valid never depends on the same side's ready, and push_ready is a
// register so upstream never sees a combinational path from pop_ready.
module skid_buf2
  import mem_wb_pipe_pkg::*;
#(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [PW-1:0] push_data,
  output logic          pop_valid,
  input  logic          pop_ready,
  output logic [PW-1:0] pop_data,
  output pipe_state_t   state
);

  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;
  logic          push;
  logic          pop;

  assign push     = push_valid && push_ready;
  assign pop      = pop_valid && pop_ready;
  assign pop_data = main_q;

  // Occupancy FSM with registered handshake outputs; main drives the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      pop_valid  <= 1'b0;
      push_ready <= 1'b1;
    end else if (flush) begin
      // Held and incoming entries are discarded; payload regs keep stale data.
      state      <= EMPTY;
      pop_valid  <= 1'b0;
      push_ready <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            main_q    <= push_data;
            state     <= ONE;
            pop_valid <= 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_q <= push_data;
          end else if (push) begin
            skid_q     <= push_data;
            state      <= TWO;
            push_ready <= 1'b0;
          end else if (pop) begin
            state     <= EMPTY;
            pop_valid <= 1'b0;
          end
        end
        TWO: begin
          if (pop) begin
            main_q     <= skid_q;
            state      <= ONE;
            push_ready <= 1'b1;
          end
        end
        default: begin
          state      <= EMPTY;
          pop_valid  <= 1'b0;
          push_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline stage: skid-buffered writeback bundle with x0 write
// suppression and a retired-instruction counter.
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5,
  parameter int RS_W   = 2,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ValidM,
  output logic              ReadyM,
  input  logic              RegWriteM,
  input  logic [RS_W-1:0]   ResultSrcM,
  input  logic [WIDTH-1:0]  ALUResultM,
  input  logic [WIDTH-1:0]  ImmExtM,
  input  logic [WIDTH-1:0]  PCPlus4M,
  input  logic [WIDTH-1:0]  ReadDataM,
  input  logic [REG_AW-1:0] RdM,
  input  logic              FlushW,
  output logic              ValidW,
  input  logic              ReadyW,
  output logic              RegWriteW,
  output logic [RS_W-1:0]   ResultSrcW,
  output logic [WIDTH-1:0]  ALUResultW,
  output logic [WIDTH-1:0]  ImmExtW,
  output logic [WIDTH-1:0]  PCPlus4W,
  output logic [WIDTH-1:0]  ReadDataW,
  output logic [REG_AW-1:0] RdW,
  output logic [CNT_W-1:0]  InstRetW,
  output pipe_state_t       state_dbg
);

  // Same field order as wb_bundle_t, sized by this instance's parameters.
  typedef struct packed {
    logic              reg_write;
    logic [RS_W-1:0]   result_src;
    logic [WIDTH-1:0]  alu_result;
    logic [REG_AW-1:0] rd;
    logic [WIDTH-1:0]  imm_ext;
    logic [WIDTH-1:0]  pc_plus4;
    logic [WIDTH-1:0]  read_data;
  } bundle_t;

  bundle_t m_bundle;
  bundle_t w_bundle;
  logic    retire;

  assign m_bundle = '{
    reg_write:  RegWriteM,
    result_src: ResultSrcM,
    alu_result: ALUResultM,
    rd:         RdM,
    imm_ext:    ImmExtM,
    pc_plus4:   PCPlus4M,
    read_data:  ReadDataM
  };

  skid_buf2 #(
    .PW($bits(bundle_t))
  ) u_skid (
    .clk        (CLK),
    .rst_n      (RST_N),
    .flush      (FlushW),
    .push_valid (ValidM),
    .push_ready (ReadyM),
    .push_data  (m_bundle),
    .pop_valid  (ValidW),
    .pop_ready  (ReadyW),
    .pop_data   (w_bundle),
    .state      (state_dbg)
  );

  // Payload shows main contents unconditionally; the write enable is gated so
  // an invalid slot or a write to x0 never reaches the register file.
  assign RegWriteW  = ValidW && w_bundle.reg_write && (w_bundle.rd != '0);
  assign ResultSrcW = w_bundle.result_src;
  assign ALUResultW = w_bundle.alu_result;
  assign RdW        = w_bundle.rd;
  assign ImmExtW    = w_bundle.imm_ext;
  assign PCPlus4W   = w_bundle.pc_plus4;
  assign ReadDataW  = w_bundle.read_data;

  assign retire = ValidW && ReadyW;

  // Retire counter: wraps naturally, a retire in a flush cycle still counts.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      InstRetW <= '0;
    end else if (retire) begin
      InstRetW <= InstRetW + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: a queue model of the held bundles, a negedge compare
// process, directed scenarios with literal expectations, and random traffic.
module tb_mem_wb_pipe;
  import mem_wb_pipe_pkg::*;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [31:0] rdata;
  } bnd_t;

  // clock / reset
  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  // stimulus
  logic        ValidM = 1'b0;
  logic        RegWriteM = 1'b0;
  logic [1:0]  ResultSrcM = '0;
  logic [31:0] ALUResultM = '0;
  logic [31:0] ImmExtM = '0;
  logic [31:0] PCPlus4M = '0;
  logic [31:0] ReadDataM = '0;
  logic [4:0]  RdM = '0;
  logic        FlushW = 1'b0;
  logic        ReadyW = 1'b0;

  // default-width instance
  logic        ReadyM, ValidW, RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW, ImmExtW, PCPlus4W, ReadDataW;
  logic [4:0]  RdW;
  logic [31:0] InstRetW;
  pipe_state_t state_dbg;

  // narrow-counter instance for the wrap check
  logic        ReadyM4, ValidW4, RegWriteW4;
  logic [1:0]  ResultSrcW4;
  logic [31:0] ALUResultW4, ImmExtW4, PCPlus4W4, ReadDataW4;
  logic [4:0]  RdW4;
  logic [3:0]  InstRetW4;
  pipe_state_t state_dbg4;

  mem_wb_pipe dut (
    .CLK(CLK), .RST_N(RST_N), .ValidM(ValidM), .ReadyM(ReadyM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM),
    .ImmExtM(ImmExtM), .PCPlus4M(PCPlus4M), .ReadDataM(ReadDataM), .RdM(RdM),
    .FlushW(FlushW), .ValidW(ValidW), .ReadyW(ReadyW), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW), .ImmExtW(ImmExtW),
    .PCPlus4W(PCPlus4W), .ReadDataW(ReadDataW), .RdW(RdW),
    .InstRetW(InstRetW), .state_dbg(state_dbg)
  );

  mem_wb_pipe #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .ValidM(ValidM), .ReadyM(ReadyM4),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM),
    .ImmExtM(ImmExtM), .PCPlus4M(PCPlus4M), .ReadDataM(ReadDataM), .RdM(RdM),
    .FlushW(FlushW), .ValidW(ValidW4), .ReadyW(ReadyW), .RegWriteW(RegWriteW4),
    .ResultSrcW(ResultSrcW4), .ALUResultW(ALUResultW4), .ImmExtW(ImmExtW4),
    .PCPlus4W(PCPlus4W4), .ReadDataW(ReadDataW4), .RdW(RdW4),
    .InstRetW(InstRetW4), .state_dbg(state_dbg4)
  );

  // scoreboard
  int          n_vec  = 0;
  int          n_fail = 0;
  bnd_t        exp_q[$];
  logic [31:0] exp_cnt = '0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void check_out(string tag, logic vw, logic rm, pipe_state_t st, bnd_t act);
    int   n;
    bnd_t e;
    pipe_state_t est;
    n   = exp_q.size();
    est = (n == 0) ? EMPTY : ((n == 1) ? ONE : TWO);
    check({tag, ".ValidW"}, vw, n != 0);
    check({tag, ".ReadyM"}, rm, n < 2);
    check({tag, ".state"}, st, est);
    if (n != 0) begin
      e = exp_q[0];
      check({tag, ".RegWriteW"}, act.rw, e.rw && (e.rd != 5'd0));
      check({tag, ".ResultSrcW"}, act.rs, e.rs);
      check({tag, ".ALUResultW"}, act.alu, e.alu);
      check({tag, ".RdW"}, act.rd, e.rd);
      check({tag, ".ImmExtW"}, act.imm, e.imm);
      check({tag, ".PCPlus4W"}, act.pc4, e.pc4);
      check({tag, ".ReadDataW"}, act.rdata, e.rdata);
    end else begin
      check({tag, ".RegWriteW_idle"}, act.rw, 1'b0);
    end
  endfunction

  // reference model: held bundles as a FIFO of at most two, plus retire count
  always @(posedge CLK or negedge RST_N) begin : model
    logic ret, acc;
    if (!RST_N) begin
      exp_q.delete();
      exp_cnt = '0;
    end else begin
      ret = ReadyW && (exp_q.size() > 0);
      acc = ValidM && (exp_q.size() < 2);
      if (ret) exp_cnt = exp_cnt + 32'd1;
      if (FlushW) begin
        exp_q.delete();
      end else begin
        if (ret) void'(exp_q.pop_front());
        if (acc) exp_q.push_back('{RegWriteM, ResultSrcM, ALUResultM, RdM,
                                   ImmExtM, PCPlus4M, ReadDataM});
      end
    end
  end

  // compare process: outputs are stable at the falling edge
  always @(negedge CLK) begin
    check_out("u32", ValidW, ReadyM, state_dbg,
              '{RegWriteW, ResultSrcW, ALUResultW, RdW, ImmExtW, PCPlus4W, ReadDataW});
    check_out("u4", ValidW4, ReadyM4, state_dbg4,
              '{RegWriteW4, ResultSrcW4, ALUResultW4, RdW4, ImmExtW4, PCPlus4W4, ReadDataW4});
    check("u32.InstRetW", InstRetW, exp_cnt);
    check("u4.InstRetW", InstRetW4, exp_cnt[3:0]);
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic neg();
    @(negedge CLK);
    #1;
  endtask

  task automatic set_bundle(logic v, logic rw, logic [4:0] rd, logic [31:0] alu);
    ValidM     = v;
    RegWriteM  = rw;
    RdM        = rd;
    ALUResultM = alu;
    ResultSrcM = 2'($urandom_range(0, 3));
    ImmExtM    = $urandom;
    PCPlus4M   = $urandom;
    ReadDataM  = $urandom;
  endtask

  task automatic rand_bundle();
    set_bundle(1'b1, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
               $urandom);
  endtask

  initial begin
    // reset state
    RST_N = 1'b0;
    repeat (3) tick();
    neg();
    check("rst.ValidW", ValidW, 1'b0);
    check("rst.ReadyM", ReadyM, 1'b1);
    check("rst.RegWriteW", RegWriteW, 1'b0);
    check("rst.payload", {ALUResultW, ImmExtW}, 64'd0);
    check("rst.payload2", {PCPlus4W, ReadDataW}, 64'd0);
    check("rst.RdRs", {RdW, ResultSrcW}, 7'd0);
    check("rst.InstRetW", InstRetW, 32'd0);
    tick();
    RST_N = 1'b1;
    tick();

    // single bundle, one-cycle latency
    ReadyW = 1'b1;
    set_bundle(1'b1, 1'b1, 5'd5, 32'h1234);
    tick();
    ValidM = 1'b0;
    neg();
    check("t1.ValidW", ValidW, 1'b1);
    check("t1.RegWriteW", RegWriteW, 1'b1);
    check("t1.ALUResultW", ALUResultW, 32'h1234);
    check("t1.InstRetW_pre", InstRetW, 32'd0);
    tick();
    neg();
    check("t1.InstRetW", InstRetW, 32'd1);
    check("t1.ValidW_after", ValidW, 1'b0);

    // eight back-to-back bundles at full rate
    for (int i = 0; i < 8; i++) begin
      rand_bundle();
      tick();
      neg();
      check("t2.ReadyM", ReadyM, 1'b1);
      check("t2.ValidW", ValidW, 1'b1);
    end
    ValidM = 1'b0;
    tick();
    neg();
    check("t2.InstRetW", InstRetW, 32'd9);
    check("t2.ValidW_end", ValidW, 1'b0);

    // stall with streaming A,B,C
    ReadyW = 1'b0;
    set_bundle(1'b1, 1'b1, 5'd1, 32'hA);
    tick();
    set_bundle(1'b1, 1'b1, 5'd2, 32'hB);
    tick();
    set_bundle(1'b1, 1'b1, 5'd3, 32'hC);
    neg();
    check("t3.ReadyM_full", ReadyM, 1'b0);
    check("t3.main_A", ALUResultW, 32'hA);
    tick();
    neg();
    check("t3.ReadyM_hold", ReadyM, 1'b0);
    check("t3.main_A_hold", ALUResultW, 32'hA);
    ReadyW = 1'b1;
    tick();
    neg();
    check("t3.main_B", ALUResultW, 32'hB);
    check("t3.ReadyM_back", ReadyM, 1'b1);
    tick();
    ValidM = 1'b0;
    neg();
    check("t3.main_C", ALUResultW, 32'hC);
    check("t3.ValidW_C", ValidW, 1'b1);
    tick();
    neg();
    check("t3.drained", ValidW, 1'b0);
    check("t3.InstRetW", InstRetW, 32'd12);

    // flush in state TWO with an incoming bundle
    ReadyW = 1'b0;
    rand_bundle();
    tick();
    rand_bundle();
    tick();
    FlushW = 1'b1;
    rand_bundle();
    tick();
    FlushW = 1'b0;
    ValidM = 1'b0;
    neg();
    check("t4.ValidW", ValidW, 1'b0);
    check("t4.ReadyM", ReadyM, 1'b1);
    check("t4.RegWriteW", RegWriteW, 1'b0);
    check("t4.InstRetW", InstRetW, 32'd12);
    tick();
    neg();
    check("t4.dropped", ValidW, 1'b0);

    // write to x0 is suppressed but still retires
    ReadyW = 1'b1;
    set_bundle(1'b1, 1'b1, 5'd0, 32'h55);
    tick();
    ValidM = 1'b0;
    neg();
    check("t5.ValidW", ValidW, 1'b1);
    check("t5.RegWriteW", RegWriteW, 1'b0);
    tick();
    neg();
    check("t5.InstRetW", InstRetW, 32'd13);

    // random traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      rand_bundle();
      ValidM = ($urandom_range(0, 9) < 7);
      ReadyW = ($urandom_range(0, 9) < 6);
      FlushW = ($urandom_range(0, 19) == 0);
      tick();
    end
    FlushW = 1'b0;

    // asynchronous reset while in state TWO
    ReadyW = 1'b0;
    rand_bundle();
    tick();
    rand_bundle();
    tick();
    #2;
    RST_N = 1'b0;
    #1;
    check("t6.ValidW", ValidW, 1'b0);
    check("t6.ReadyM", ReadyM, 1'b1);
    check("t6.RegWriteW", RegWriteW, 1'b0);
    check("t6.ALUResultW", ALUResultW, 32'd0);
    check("t6.InstRetW", InstRetW, 32'd0);
    check("t6.state", state_dbg, EMPTY);
    ValidM = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    tick();

    // 17 retires on the 4-bit counter wrap to 1
    ReadyW = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rand_bundle();
      tick();
    end
    ValidM = 1'b0;
    tick();
    neg();
    check("t7.InstRetW32", InstRetW, 32'd17);
    check("t7.InstRetW4", InstRetW4, 4'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
